sha1_tag_dispatch: RTL and testbench
====================================

SHA1_TAG_DISPATCH -- requirements
Module: sha1_tag_dispatch

Interface
REQ-001 Parameter TAG_WIDTH, default 10: width of the sequence tag carried with every job.
REQ-002 Parameter ENGINE_NUM, default 4: number of SHA1 engines served.
REQ-003 Parameter MAX_OUTSTANDING, default 1024: reorder-buffer depth; SHALL be <= 2**TAG_WIDTH.
REQ-004 Parameter DATA_WIDTH, default 512: job payload width.
REQ-005 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 init_done  input  1  reorder-buffer RAM initialisation complete.
REQ-008 job_valid  input  1  upstream job present.
REQ-009 job_data  input  DATA_WIDTH  upstream job payload.
REQ-010 job_ready  output  1  job accepted on the cycle job_valid & job_ready.
REQ-011 eng_busy  input  ENGINE_NUM  per-engine busy flag.
REQ-012 eng_start  output  ENGINE_NUM  one-hot, one-cycle start pulse to the selected engine.
REQ-013 eng_data  output  DATA_WIDTH  payload registered with the accepted job.
REQ-014 eng_tag  output  TAG_WIDTH  tag registered with the accepted job.
REQ-015 credit_ret  input  1  one pulse per in-order result read by the downstream consumer.
REQ-016 outstanding  output  TAG_WIDTH+1  count of tags issued and not yet returned.
REQ-017 credit_err  output  1  sticky flag: credit_ret received while outstanding == 0.

Function
REQ-018 The FSM SHALL have states ST_IDLE, ST_ARB, ST_ISSUE and ST_WAIT.
REQ-019 job_ready SHALL be 1 only when the FSM is in ST_IDLE, init_done == 1 and outstanding < MAX_OUTSTANDING.
REQ-020 On acceptance, the block SHALL register job_data into eng_data and tag_cnt into eng_tag; tag_cnt SHALL then increment modulo 2**TAG_WIDTH; the FSM SHALL go ST_IDLE -> ST_ARB.
REQ-021 In ST_ARB, the block SHALL search for the first engine with eng_busy == 0, starting at rr_ptr and wrapping modulo ENGINE_NUM; if one is found, it SHALL latch its index and go to ST_ISSUE; if none is found, it SHALL stay in ST_ARB and keep the job.
REQ-022 In ST_ISSUE, the block SHALL drive eng_start[sel] = 1 for exactly one cycle and SHALL set rr_ptr = (sel+1) mod ENGINE_NUM; next state ST_WAIT.
REQ-023 In ST_WAIT, the block SHALL go to ST_IDLE when eng_busy[sel] == 1 or after 2 cycles in ST_WAIT, whichever comes first; this absorbs the engine busy latency.
REQ-024 eng_data and eng_tag SHALL stay stable from acceptance until the FSM returns to ST_IDLE.
REQ-025 Minimum job spacing SHALL be 4 cycles: accept, arb, issue, wait.
REQ-026 outstanding SHALL increment on acceptance and decrement on credit_ret.
REQ-027 If acceptance and credit_ret occur in the same cycle, outstanding SHALL be unchanged.
REQ-028 If credit_ret arrives while outstanding == 0 with no acceptance in the same cycle, outstanding SHALL stay 0 and credit_err SHALL be set to 1.
REQ-029 When outstanding == MAX_OUTSTANDING, job_ready SHALL be 0; the cycle after a credit_ret it SHALL rise to 1 if the FSM is in ST_IDLE.
REQ-030 Tag wrap from 2**TAG_WIDTH-1 to 0 SHALL be seamless: no bubble and no flag.
REQ-031 Deassertion of init_done mid-job SHALL NOT abort the job in flight; it SHALL only block new acceptances.

Reset
REQ-032 On rst_n == 0 at a clock edge, the block SHALL set fsm = ST_IDLE, tag_cnt = 0, rr_ptr = 0, outstanding = 0, credit_err = 0, eng_start = 0, eng_data = 0 and eng_tag = 0.
REQ-033 job_ready SHALL be 0 during reset and until init_done == 1.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight job; no eng_start pulse SHALL follow reset.

Verification
REQ-035 Basic issue: reset, init_done = 1, all engines idle, 3 jobs -> eng_start pulses 0001, 0010, 0100; eng_tag values 0, 1, 2; outstanding = 3.
REQ-036 All engines busy: eng_busy = 1111 for 10 cycles, then engine 2 freed -> FSM held in ST_ARB, then a single eng_start = 0100 with the job data unchanged.
REQ-037 Credit limit: MAX_OUTSTANDING = 4, 4 jobs, no credit_ret -> job_ready = 0; one credit_ret pulse -> job_ready = 1 the next idle cycle; the 5th job gets tag 4.
REQ-038 Simultaneous events: acceptance and credit_ret in the same cycle at outstanding = 2 -> outstanding stays 2.
REQ-039 Error and wrap: TAG_WIDTH = 3, 9 jobs with credits returned -> tags 0..7 then 0; a credit_ret with outstanding = 0 -> credit_err = 1 and outstanding = 0.
REQ-040 Reset mid-job: rst_n pulsed while in ST_ISSUE -> no eng_start pulse; all outputs at reset values; next job gets tag 0 on engine 0.

Source files
------------

// File: rtl/sha1_tag_dispatch.sv
// sha1_tag_dispatch: accepts jobs from upstream, stamps each with a sequence
// tag, dispatches it round-robin to a free SHA1 engine and tracks the number
// of tags in flight against the downstream reorder-buffer depth.
module sha1_tag_dispatch #(
  parameter int TAG_WIDTH       = 10,
  parameter int ENGINE_NUM      = 4,
  parameter int MAX_OUTSTANDING = 1024,
  parameter int DATA_WIDTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  job_valid,
  input  logic [DATA_WIDTH-1:0] job_data,
  output logic                  job_ready,
  input  logic [ENGINE_NUM-1:0] eng_busy,
  output logic [ENGINE_NUM-1:0] eng_start,
  output logic [DATA_WIDTH-1:0] eng_data,
  output logic [TAG_WIDTH-1:0]  eng_tag,
  input  logic                  credit_ret,
  output logic [TAG_WIDTH:0]    outstanding,
  output logic                  credit_err
);

  localparam int ENG_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam logic [TAG_WIDTH:0] MAX_OUT   = (TAG_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [ENG_W:0]     ENG_CNT   = (ENG_W+1)'(ENGINE_NUM);
  localparam logic [ENG_W-1:0]   ENG_LAST  = ENG_W'(ENGINE_NUM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ISSUE, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_cnt_q, tag_cnt_d;
  logic [ENG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ENG_W-1:0]        sel_q, sel_d;
  logic                    wait_q, wait_d;
  logic [TAG_WIDTH:0]      outstanding_q, outstanding_d;
  logic                    credit_err_q, credit_err_d;
  logic [ENGINE_NUM-1:0]   eng_start_q, eng_start_d;
  logic [DATA_WIDTH-1:0]   eng_data_q, eng_data_d;
  logic [TAG_WIDTH-1:0]    eng_tag_q, eng_tag_d;

  logic                    accept;
  logic                    free_found;
  logic [ENG_W-1:0]        free_idx;
  logic [ENG_W:0]          cand;

  // Ready only in idle, after RAM init, with reorder-buffer room, and never under reset.
  assign job_ready = rst_n && init_done && (state_q == ST_IDLE) && (outstanding_q < MAX_OUT);
  assign accept    = job_valid && job_ready;

  // Round-robin search: first idle engine at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    free_found = 1'b0;
    free_idx   = rr_ptr_q;
    cand       = '0;
    for (int i = 0; i < ENGINE_NUM; i++) begin
      cand = {1'b0, rr_ptr_q} + (ENG_W+1)'(i);
      if (cand >= ENG_CNT) cand = cand - ENG_CNT;
      if (!free_found && !eng_busy[cand[ENG_W-1:0]]) begin
        free_found = 1'b1;
        free_idx   = cand[ENG_W-1:0];
      end
    end
  end

  // Dispatch FSM: next state, job capture, engine selection and start pulse.
  always_comb begin
    state_d     = state_q;
    tag_cnt_d   = tag_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    wait_d      = wait_q;
    eng_data_d  = eng_data_q;
    eng_tag_d   = eng_tag_q;
    eng_start_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          eng_data_d = job_data;
          eng_tag_d  = tag_cnt_q;
          tag_cnt_d  = tag_cnt_q + TAG_WIDTH'(1);
          state_d    = ST_ARB;
        end
      end
      ST_ARB: begin
        if (free_found) begin
          sel_d                 = free_idx;
          eng_start_d[free_idx] = 1'b1;
          state_d               = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rr_ptr_d = (sel_q == ENG_LAST) ? '0 : sel_q + ENG_W'(1);
        wait_d   = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Leave once the engine reports busy, or after the second wait cycle.
        if (eng_busy[sel_q] || wait_q) state_d = ST_IDLE;
        else                           wait_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Credit accounting: simultaneous issue and return cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    credit_err_d  = credit_err_q;
    if (accept && !credit_ret) begin
      outstanding_d = outstanding_q + (TAG_WIDTH+1)'(1);
    end else if (!accept && credit_ret) begin
      if (outstanding_q == '0) credit_err_d  = 1'b1;
      else                     outstanding_d = outstanding_q - (TAG_WIDTH+1)'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tag_cnt_q     <= '0;
      rr_ptr_q      <= '0;
      sel_q         <= '0;
      wait_q        <= 1'b0;
      outstanding_q <= '0;
      credit_err_q  <= 1'b0;
      eng_start_q   <= '0;
      eng_data_q    <= '0;
      eng_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      tag_cnt_q     <= tag_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_q         <= sel_d;
      wait_q        <= wait_d;
      outstanding_q <= outstanding_d;
      credit_err_q  <= credit_err_d;
      eng_start_q   <= eng_start_d;
      eng_data_q    <= eng_data_d;
      eng_tag_q     <= eng_tag_d;
    end
  end

  // A start pulse seen while reset is low would launch an engine on a job
  // that reset is discarding, so the pulse is masked by rst_n.
  assign eng_start   = eng_start_q & {ENGINE_NUM{rst_n}};
  assign eng_data    = eng_data_q;
  assign eng_tag     = eng_tag_q;
  assign outstanding = outstanding_q;
  assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_sha1_tag_dispatch.sv
// Directed bench for sha1_tag_dispatch: small tag space and credit limit so
// wrap-around and back-pressure are reached with a handful of jobs.
module tb_sha1_tag_dispatch;

  localparam int TW = 3;
  localparam int EN = 4;
  localparam int MO = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic          job_valid;
  logic [DW-1:0] job_data;
  logic          job_ready;
  logic [EN-1:0] eng_busy;
  logic [EN-1:0] eng_start;
  logic [DW-1:0] eng_data;
  logic [TW-1:0] eng_tag;
  logic          credit_ret;
  logic [TW:0]   outstanding;
  logic          credit_err;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int p0;

  sha1_tag_dispatch #(
    .TAG_WIDTH(TW), .ENGINE_NUM(EN), .MAX_OUTSTANDING(MO), .DATA_WIDTH(DW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .job_valid(job_valid), .job_data(job_data), .job_ready(job_ready),
    .eng_busy(eng_busy), .eng_start(eng_start), .eng_data(eng_data),
    .eng_tag(eng_tag), .credit_ret(credit_ret), .outstanding(outstanding),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Count start pulses, sampled mid-cycle.
  always @(negedge clk) if (eng_start != '0) n_pulses++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_credit();
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!job_ready && n < 50) begin
      tick();
      n++;
    end
    check({name, "_ready"}, job_ready, 1);
  endtask

  task automatic accept_job(input logic [DW-1:0] d, input string name);
    wait_ready(name);
    job_valid = 1'b1;
    job_data  = d;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic expect_start(input logic [EN-1:0] exp_start, input logic [DW-1:0] d,
                              input logic [TW-1:0] exp_tag, input string name);
    int n = 0;
    while (eng_start == '0 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_start"}, eng_start, exp_start);
    check({name, "_data"},  eng_data,  d);
    check({name, "_tag"},   eng_tag,   exp_tag);
    tick();
    check({name, "_1cyc"},  eng_start, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; init_done = 1'b0; job_valid = 1'b0; job_data = '0;
    eng_busy = '0; credit_ret = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready",  job_ready,   0);
    check("rst_start",  eng_start,   0);
    check("rst_out",    outstanding, 0);
    check("rst_err",    credit_err,  0);
    check("rst_tag",    eng_tag,     0);
    check("rst_data",   eng_data,    0);
    rst_n = 1'b1;
    tick();
    check("noinit_ready", job_ready, 0);
    init_done = 1'b1;
    #1;
    check("init_ready", job_ready, 1);

    // Basic issue: engines 0,1,2 with tags 0,1,2
    accept_job(32'hA000_0000, "b0"); expect_start(4'b0001, 32'hA000_0000, 3'd0, "b0");
    accept_job(32'hA000_0001, "b1"); expect_start(4'b0010, 32'hA000_0001, 3'd1, "b1");
    accept_job(32'hA000_0002, "b2"); expect_start(4'b0100, 32'hA000_0002, 3'd2, "b2");
    check("basic_out", outstanding, 3);
    repeat (3) pulse_credit();
    check("drain_out", outstanding, 0);

    // All engines busy: job held in arbitration, then engine 2 frees
    eng_busy = 4'b1111;
    accept_job(32'hB0B0_0003, "busy");
    p0 = n_pulses;
    repeat (10) tick();
    check("busy_no_start", n_pulses - p0, 0);
    check("busy_ready",    job_ready,     0);
    check("busy_data",     eng_data,      32'hB0B0_0003);
    eng_busy = 4'b1011;
    expect_start(4'b0100, 32'hB0B0_0003, 3'd3, "busy");
    check("busy_single", n_pulses - p0, 1);
    eng_busy = '0;

    // Credit limit: fill to 4 outstanding, then one credit frees a slot
    accept_job(32'hC000_0004, "c4"); expect_start(4'b1000, 32'hC000_0004, 3'd4, "c4");
    accept_job(32'hC000_0005, "c5"); expect_start(4'b0001, 32'hC000_0005, 3'd5, "c5");
    accept_job(32'hC000_0006, "c6"); expect_start(4'b0010, 32'hC000_0006, 3'd6, "c6");
    job_valid = 1'b1;
    job_data  = 32'hC000_0007;
    repeat (6) tick();
    check("full_ready", job_ready,   0);
    check("full_out",   outstanding, 4);
    pulse_credit();
    check("credit_out",   outstanding, 3);
    check("credit_ready", job_ready,   1);
    tick();
    job_valid = 1'b0;
    check("refill_out", outstanding, 4);
    expect_start(4'b0100, 32'hC000_0007, 3'd7, "c7");

    // Simultaneous acceptance and credit at outstanding == 2; tag wraps 7 -> 0
    pulse_credit();
    pulse_credit();
    check("pre_sim_out", outstanding, 2);
    wait_ready("sim");
    job_valid  = 1'b1;
    credit_ret = 1'b1;
    job_data   = 32'hD000_0000;
    tick();
    job_valid  = 1'b0;
    credit_ret = 1'b0;
    check("sim_out", outstanding, 2);
    expect_start(4'b1000, 32'hD000_0000, 3'd0, "wrap");

    // Credit underflow
    pulse_credit();
    pulse_credit();
    check("pre_err_out", outstanding, 0);
    check("pre_err",     credit_err,  0);
    pulse_credit();
    check("err_flag", credit_err,  1);
    check("err_out",  outstanding, 0);

    // init_done drop mid-job: job completes, new jobs blocked
    accept_job(32'hE000_0001, "init");
    init_done = 1'b0;
    expect_start(4'b0001, 32'hE000_0001, 3'd1, "init");
    repeat (4) tick();
    check("init_block", job_ready, 0);
    init_done = 1'b1;
    #1;
    check("init_resume", job_ready, 1);

    // Reset while in ST_ISSUE: no pulse, reset values, restart at tag 0 / engine 0
    accept_job(32'hF000_0002, "rst");
    tick();
    p0 = n_pulses;
    rst_n = 1'b0;
    #1;
    check("rst_mid_start", eng_start, 0);
    check("rst_mid_ready", job_ready, 0);
    tick();
    check("rst_mid_out",  outstanding, 0);
    check("rst_mid_err",  credit_err,  0);
    check("rst_mid_tag",  eng_tag,     0);
    check("rst_mid_data", eng_data,    0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_no_pulse", n_pulses - p0, 0);
    accept_job(32'h1234_5678, "post");
    expect_start(4'b0001, 32'h1234_5678, 3'd0, "post");
    check("post_out", outstanding, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
